// File: rtl/ql_ioff_bank.sv
// Multi-channel IO capture register bank: DEPTH-stage pipeline per channel with
// per-channel polarity select, fill-tracking valid flag and a scan chain through every data flop.
module ql_ioff_bank #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             CK,
  input  logic             global_resetn,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] INV,
  input  logic             EN,
  input  logic             SE,
  input  logic             SI,
  output logic             SO,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID
);

  localparam int N  = WIDTH * DEPTH;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // Stage k channel c lives at chain bit k*WIDTH + c, so a capture is a WIDTH-bit
  // shift of the same vector the scan path shifts by one.
  logic [N-1:0]  chain_q, chain_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;

  // Next-state selection: scan beats capture, capture beats hold.
  always_comb begin
    chain_d = chain_q;
    cnt_d   = cnt_q;
    if (SE) begin
      chain_d = (chain_q << 1) | N'(SI);
      cnt_d   = {CW{1'b0}};
    end else if (EN) begin
      chain_d = (chain_q << WIDTH) | N'(D ^ INV);
      cnt_d   = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CW'(1);
    end else begin
      chain_d = chain_q;
      cnt_d   = cnt_q;
    end
    valid_d = (cnt_d == CNT_FULL);
  end

  // State registers with synchronous set-type reset.
  always_ff @(posedge CK) begin
    if (!global_resetn) begin
      chain_q <= {DEPTH{RESET_VAL}};
      cnt_q   <= {CW{1'b0}};
      valid_q <= 1'b0;
    end else begin
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign Q       = chain_q[N-1 -: WIDTH];
  assign SO      = chain_q[N-1];
  assign Q_VALID = valid_q;

endmodule

// File: tb/tb_ql_ioff_bank.sv
// Directed self-checking bench for ql_ioff_bank: main instance WIDTH=8/DEPTH=2/RESET_VAL=FF,
// second instance DEPTH=1/RESET_VAL=00 sharing the same stimulus.
module tb_ql_ioff_bank;

  logic       CK = 1'b0;
  logic       global_resetn;
  logic [7:0] D, INV;
  logic       EN, SE, SI;
  logic       SO, Q_VALID;
  logic [7:0] Q;
  logic       SO1, Q_VALID1;
  logic [7:0] Q1;

  int total = 0;
  int bad   = 0;

  always #5 CK = ~CK;

  ql_ioff_bank #(.WIDTH(8), .DEPTH(2), .RESET_VAL(8'hFF)) dut (
    .CK(CK), .global_resetn(global_resetn), .D(D), .INV(INV), .EN(EN),
    .SE(SE), .SI(SI), .SO(SO), .Q(Q), .Q_VALID(Q_VALID)
  );

  ql_ioff_bank #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) dut1 (
    .CK(CK), .global_resetn(global_resetn), .D(D), .INV(INV), .EN(EN),
    .SE(SE), .SI(SI), .SO(SO1), .Q(Q1), .Q_VALID(Q_VALID1)
  );

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset();
    global_resetn = 1'b0; D = 8'h00; INV = 8'h00; EN = 1'b1; SE = 1'b0; SI = 1'b0;
    for (int n = 0; n < 2; n++) begin
      tick();
      total++; if (Q !== 8'hFF) begin bad++; $display("FAIL reset_q cyc%0d got=%h exp=ff", n, Q); end
      total++; if (SO !== 1'b1) begin bad++; $display("FAIL reset_so cyc%0d got=%b exp=1", n, SO); end
      total++; if (Q_VALID !== 1'b0) begin bad++; $display("FAIL reset_qv cyc%0d got=%b exp=0", n, Q_VALID); end
      total++; if (Q1 !== 8'h00) begin bad++; $display("FAIL reset_q1 cyc%0d got=%h exp=00", n, Q1); end
      total++; if (Q_VALID1 !== 1'b0) begin bad++; $display("FAIL reset_qv1 cyc%0d got=%b exp=0", n, Q_VALID1); end
    end
  endtask

  task automatic test_fill();
    global_resetn = 1'b1; EN = 1'b1; INV = 8'h00;
    D = 8'hA5; tick();
    total++; if (Q !== 8'hFF) begin bad++; $display("FAIL fill_e1_q got=%h exp=ff", Q); end
    total++; if (Q_VALID !== 1'b0) begin bad++; $display("FAIL fill_e1_qv got=%b exp=0", Q_VALID); end
    total++; if (Q1 !== 8'hA5) begin bad++; $display("FAIL fill_d1_q got=%h exp=a5", Q1); end
    total++; if (Q_VALID1 !== 1'b1) begin bad++; $display("FAIL fill_d1_qv got=%b exp=1", Q_VALID1); end
    D = 8'h3C; tick();
    total++; if (Q !== 8'hA5) begin bad++; $display("FAIL fill_e2_q got=%h exp=a5", Q); end
    total++; if (Q_VALID !== 1'b1) begin bad++; $display("FAIL fill_e2_qv got=%b exp=1", Q_VALID); end
    D = 8'h00; tick();
    total++; if (Q !== 8'h3C) begin bad++; $display("FAIL fill_e3_q got=%h exp=3c", Q); end
    total++; if (Q_VALID !== 1'b1) begin bad++; $display("FAIL fill_e3_qv got=%b exp=1", Q_VALID); end
  endtask

  task automatic test_inv_hold();
    logic [7:0] inv_tab [3];
    inv_tab[0] = 8'hFF; inv_tab[1] = 8'h00; inv_tab[2] = 8'hF0;
    // stage0 = A5 ^ 0F = AA; Q shows the previously captured 00
    INV = 8'h0F; EN = 1'b1; D = 8'hA5; tick();
    total++; if (Q !== 8'h00) begin bad++; $display("FAIL inv_cap_q got=%h exp=00", Q); end
    EN = 1'b0; D = 8'h00;
    for (int n = 0; n < 3; n++) begin
      INV = inv_tab[n];
      tick();
      total++; if (Q !== 8'h00) begin bad++; $display("FAIL hold_q cyc%0d got=%h exp=00", n, Q); end
      total++; if (Q_VALID !== 1'b1) begin bad++; $display("FAIL hold_qv cyc%0d got=%b exp=1", n, Q_VALID); end
    end
    INV = 8'h00; EN = 1'b1; tick();
    total++; if (Q !== 8'hAA) begin bad++; $display("FAIL inv_out_q got=%h exp=aa", Q); end
  endtask

  task automatic test_scan();
    logic [15:0] so_exp, si_pat;
    so_exp = 16'b0101_1010_1100_0011; // 5A MSB first, then C3 MSB first
    si_pat = 16'hBEEF;
    INV = 8'h00; EN = 1'b1;
    D = 8'h5A; tick();
    D = 8'hC3; tick();
    total++; if (Q !== 8'h5A) begin bad++; $display("FAIL preload_q got=%h exp=5a", Q); end
    SE = 1'b1; EN = 1'b0;
    for (int j = 0; j < 16; j++) begin
      total++; if (SO !== so_exp[15-j]) begin bad++; $display("FAIL scan_so bit%0d got=%b exp=%b", j, SO, so_exp[15-j]); end
      SI = si_pat[j];
      tick();
      total++; if (Q_VALID !== 1'b0) begin bad++; $display("FAIL scan_qv bit%0d got=%b exp=0", j, Q_VALID); end
    end
    // The first bit shifted in ends deepest: chain[15-j] = BEEF[j], so
    // stage1 = bit-reverse(EF) = F7 and stage0 = bit-reverse(BE) = 7D.
    SE = 1'b0; EN = 1'b0; tick();
    total++; if (Q !== 8'hF7) begin bad++; $display("FAIL unload_q got=%h exp=f7", Q); end
    total++; if (Q_VALID !== 1'b0) begin bad++; $display("FAIL unload_qv got=%b exp=0", Q_VALID); end
    EN = 1'b1; D = 8'h00; tick();
    total++; if (Q !== 8'h7D) begin bad++; $display("FAIL unload_s0 got=%h exp=7d", Q); end
    total++; if (Q_VALID !== 1'b0) begin bad++; $display("FAIL refill1_qv got=%b exp=0", Q_VALID); end
    tick();
    total++; if (Q !== 8'h00) begin bad++; $display("FAIL refill2_q got=%h exp=00", Q); end
    total++; if (Q_VALID !== 1'b1) begin bad++; $display("FAIL refill2_qv got=%b exp=1", Q_VALID); end
  endtask

  task automatic test_collision();
    // stage1=C0, stage0=01 -> one shift gives chain 8002
    SE = 1'b0; EN = 1'b1; INV = 8'h00;
    D = 8'hC0; tick();
    D = 8'h01; tick();
    SE = 1'b1; EN = 1'b1; D = 8'h00; SI = 1'b0; tick();
    total++; if (Q !== 8'h80) begin bad++; $display("FAIL collide_q got=%h exp=80", Q); end
    total++; if (SO !== 1'b1) begin bad++; $display("FAIL collide_so got=%b exp=1", SO); end
    total++; if (Q_VALID !== 1'b0) begin bad++; $display("FAIL collide_qv got=%b exp=0", Q_VALID); end
  endtask

  task automatic test_reset_mid_scan();
    SE = 1'b1; EN = 1'b0; SI = 1'b0;
    for (int n = 0; n < 5; n++) tick();
    global_resetn = 1'b0; tick();
    total++; if (Q !== 8'hFF) begin bad++; $display("FAIL midscan_q got=%h exp=ff", Q); end
    total++; if (SO !== 1'b1) begin bad++; $display("FAIL midscan_so got=%b exp=1", SO); end
    total++; if (Q_VALID !== 1'b0) begin bad++; $display("FAIL midscan_qv got=%b exp=0", Q_VALID); end
    total++; if (Q1 !== 8'h00) begin bad++; $display("FAIL midscan_q1 got=%h exp=00", Q1); end
    total++; if (SO1 !== 1'b0) begin bad++; $display("FAIL midscan_so1 got=%b exp=0", SO1); end
    total++; if (Q_VALID1 !== 1'b0) begin bad++; $display("FAIL midscan_qv1 got=%b exp=0", Q_VALID1); end
    global_resetn = 1'b1; SE = 1'b0; EN = 1'b1; INV = 8'h00; D = 8'h3C; tick();
    total++; if (Q1 !== 8'h3C) begin bad++; $display("FAIL post_q1 got=%h exp=3c", Q1); end
    total++; if (Q_VALID1 !== 1'b1) begin bad++; $display("FAIL post_qv1 got=%b exp=1", Q_VALID1); end
    total++; if (Q !== 8'hFF) begin bad++; $display("FAIL post_q got=%h exp=ff", Q); end
    total++; if (Q_VALID !== 1'b0) begin bad++; $display("FAIL post_qv got=%b exp=0", Q_VALID); end
  endtask

  initial begin
    global_resetn = 1'b0; D = 8'h00; INV = 8'h00; EN = 1'b0; SE = 1'b0; SI = 1'b0;
    #2;
    test_reset();
    test_fill();
    test_inv_hold();
    test_scan();
    test_collision();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
